// File: rtl/pipe_perf_monitor_if.sv
// Writeback/hazard observation inputs, event counters and trace-drain handshake
// bundled for pipe_perf_monitor. master = the monitor, slave = pipeline/consumer side.
interface pipe_perf_monitor_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 32
);
   logic              en;
   logic              clr;
   logic              wb_en;
   logic [REG_W-1:0]  wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic              freeze;
   logic              flush;
   logic              tr_ready;

   logic [CNT_W-1:0]  cyc_cnt;
   logic [CNT_W-1:0]  ret_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              tr_valid;
   logic [REG_W-1:0]  tr_dest;
   logic [DATA_W-1:0] tr_data;
   logic [CNT_W-1:0]  tr_cycle;
   logic              tr_ovf;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      input  en, clr, wb_en, wb_dest, wb_data, freeze, flush, tr_ready,
      output cyc_cnt, ret_cnt, stall_cnt, flush_cnt,
             tr_valid, tr_dest, tr_data, tr_cycle, tr_ovf, drop_cnt
   );

   modport slave (
      output en, clr, wb_en, wb_dest, wb_data, freeze, flush, tr_ready,
      input  cyc_cnt, ret_cnt, stall_cnt, flush_cnt,
             tr_valid, tr_dest, tr_data, tr_cycle, tr_ovf, drop_cnt
   );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance counters plus a committed-writeback trace FIFO.
// The trace FIFO, tr_*, tr_ovf and drop_cnt exist only when PERF_TRACE_EN is defined.
module pipe_perf_monitor #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   pipe_perf_monitor_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   logic             commit_c;
   logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, stall_q, stall_d, flush_q, flush_d;

   assign commit_c = bus.en & bus.wb_en & (bus.wb_dest != '0);

   // Event counters: clear wins, otherwise count only while enabled
   always_comb begin
      cyc_d   = cyc_q;
      ret_d   = ret_q;
      stall_d = stall_q;
      flush_d = flush_q;
      if (bus.clr) begin
         cyc_d   = '0;
         ret_d   = '0;
         stall_d = '0;
         flush_d = '0;
      end else if (bus.en) begin
         cyc_d   = sat_inc(cyc_q, 1'b1);
         ret_d   = sat_inc(ret_q, commit_c);
         stall_d = sat_inc(stall_q, bus.freeze);
         flush_d = sat_inc(flush_q, bus.flush);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_q   <= '0;
         ret_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         ret_q   <= ret_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign bus.cyc_cnt   = cyc_q;
   assign bus.ret_cnt   = ret_q;
   assign bus.stall_cnt = stall_q;
   assign bus.flush_cnt = flush_q;

`ifdef PERF_TRACE_EN
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;
   localparam int unsigned ENT_W = REG_W + DATA_W + CNT_W;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic             valid_q, valid_d, ovf_q, ovf_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             full_c, pop_c, push_c, drop_ev_c;
   logic [ENT_W-1:0] wr_ent_c;

   assign wr_ent_c  = {bus.wb_dest, bus.wb_data, cyc_q};
   assign full_c    = (wptr_q == (rptr_q ^ PTR_W'(DEPTH)));
   assign pop_c     = valid_q & bus.tr_ready;
   assign push_c    = commit_c & (~full_c | pop_c);
   assign drop_ev_c = commit_c & full_c & ~pop_c;

   // Pointer/flag update; the head register is preloaded with whatever the read pointer lands on
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      valid_d = 1'b0;
      head_d  = '0;
      if (!bus.clr) begin
         if (push_c) wptr_d = wptr_q + PTR_W'(1);
         if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
         if (drop_ev_c) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc(drop_q, 1'b1);
         end
         valid_d = (wptr_d != rptr_d);
         if (valid_d) begin
            // Landing on the slot being written this cycle means the head is the incoming event
            head_d = (rptr_d == wptr_q) ? wr_ent_c : mem_q[rptr_d[AW-1:0]];
         end
      end else begin
         wptr_d = '0;
         rptr_d = '0;
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_c && !bus.clr) mem_q[wptr_q[AW-1:0]] <= wr_ent_c;
   end

   assign bus.tr_valid = valid_q;
   assign bus.tr_dest  = head_q[ENT_W-1 -: REG_W];
   assign bus.tr_data  = head_q[CNT_W +: DATA_W];
   assign bus.tr_cycle = head_q[CNT_W-1:0];
   assign bus.tr_ovf   = ovf_q;
   assign bus.drop_cnt = drop_q;
`else
   logic unused_trace;
   assign unused_trace = ^{bus.tr_ready, 32'(DEPTH)};

   assign bus.tr_valid = 1'b0;
   assign bus.tr_dest  = '0;
   assign bus.tr_data  = '0;
   assign bus.tr_cycle = '0;
   assign bus.tr_ovf   = 1'b0;
   assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_pipe_perf_monitor;

`ifdef PERF_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif
   localparam int unsigned DEPTH_M = 4;
   localparam logic [63:0] MAX32   = 64'hFFFF_FFFF;

   logic clk;
   logic rst_n;

   pipe_perf_monitor_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) m_if ();
   pipe_perf_monitor_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  s_if ();

   pipe_perf_monitor #(.DATA_W(32), .REG_W(5), .CNT_W(32), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(m_if)
   );
   pipe_perf_monitor #(.DATA_W(32), .REG_W(5), .CNT_W(4), .DEPTH(4)) dut_sat (
      .clk_i(clk), .rst_ni(rst_n), .bus(s_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] data;
      logic [31:0] cyc;
   } ent_t;

   ent_t        m_q[$];
   logic [63:0] m_cyc, m_ret, m_stall, m_flush, m_drop;
   logic        m_ovf;

   typedef struct {
      logic        en, clr, wb_en;
      logic [4:0]  dest;
      logic [31:0] data;
      logic        frz, fl, rdy;
      logic [31:0] e_cyc, e_ret, e_stall, e_flush;
      logic        e_valid;
      logic [4:0]  e_dest;
      logic [31:0] e_data, e_tcyc;
   } vec_t;

   vec_t tv[12];

   function automatic vec_t mk(input int unsigned en, clr, wb, dest, data, frz, fl, rdy,
                               input int unsigned cyc, ret, stall, flush,
                               input int unsigned valid, hdest, hdata, hcyc);
      vec_t v;
      v.en = 1'(en); v.clr = 1'(clr); v.wb_en = 1'(wb); v.dest = 5'(dest); v.data = 32'(data);
      v.frz = 1'(frz); v.fl = 1'(fl); v.rdy = 1'(rdy);
      v.e_cyc = 32'(cyc); v.e_ret = 32'(ret); v.e_stall = 32'(stall); v.e_flush = 32'(flush);
      v.e_valid = 1'(valid); v.e_dest = 5'(hdest); v.e_data = 32'(hdata); v.e_tcyc = 32'(hcyc);
      return v;
   endfunction

   function automatic logic [63:0] sat(input logic [63:0] v, input logic [63:0] maxv);
      return (v < maxv) ? v + 64'd1 : v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cyc = '0; m_ret = '0; m_stall = '0; m_flush = '0; m_drop = '0; m_ovf = 1'b0;
      m_q.delete();
   endtask

   // Reference behaviour at one rising edge, from the inputs present at that edge
   task automatic model_edge();
      bit   commit;
      bit   pop;
      ent_t e;
      commit = m_if.en && m_if.wb_en && (m_if.wb_dest != 5'd0);
      if (m_if.clr) begin
         model_reset();
         return;
      end
      if (TRACE) begin
         pop    = (m_q.size() > 0) && m_if.tr_ready;
         e.dest = m_if.wb_dest;
         e.data = m_if.wb_data;
         e.cyc  = m_cyc[31:0];
         if (pop) m_q.delete(0);
         if (commit) begin
            if (m_q.size() < DEPTH_M) m_q.push_back(e);
            else begin
               m_ovf  = 1'b1;
               m_drop = sat(m_drop, MAX32);
            end
         end
      end
      if (m_if.en) begin
         m_cyc = sat(m_cyc, MAX32);
         if (commit)      m_ret   = sat(m_ret, MAX32);
         if (m_if.freeze) m_stall = sat(m_stall, MAX32);
         if (m_if.flush)  m_flush = sat(m_flush, MAX32);
      end
   endtask

   task automatic compare_all(input string tag);
      bit exp_v;
      exp_v = (m_q.size() > 0);
      chk({tag, " cyc_cnt"},   64'(m_if.cyc_cnt),   m_cyc);
      chk({tag, " ret_cnt"},   64'(m_if.ret_cnt),   m_ret);
      chk({tag, " stall_cnt"}, 64'(m_if.stall_cnt), m_stall);
      chk({tag, " flush_cnt"}, 64'(m_if.flush_cnt), m_flush);
      chk({tag, " drop_cnt"},  64'(m_if.drop_cnt),  m_drop);
      chk({tag, " tr_ovf"},    64'(m_if.tr_ovf),    64'(m_ovf));
      chk({tag, " tr_valid"},  64'(m_if.tr_valid),  64'(exp_v));
      chk({tag, " tr_dest"},   64'(m_if.tr_dest),   exp_v ? 64'(m_q[0].dest) : 64'd0);
      chk({tag, " tr_data"},   64'(m_if.tr_data),   exp_v ? 64'(m_q[0].data) : 64'd0);
      chk({tag, " tr_cycle"},  64'(m_if.tr_cycle),  exp_v ? 64'(m_q[0].cyc)  : 64'd0);
   endtask

   task automatic set_in(input bit en, clr, wb, input logic [4:0] dest, input logic [31:0] data,
                         input bit frz, fl, rdy);
      m_if.en = en; m_if.clr = clr; m_if.wb_en = wb; m_if.wb_dest = dest; m_if.wb_data = data;
      m_if.freeze = frz; m_if.flush = fl; m_if.tr_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input int n);
      set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_if.en = 1'b0; s_if.clr = 1'b0; s_if.wb_en = 1'b0; s_if.wb_dest = '0; s_if.wb_data = '0;
      s_if.freeze = 1'b0; s_if.flush = 1'b0; s_if.tr_ready = 1'b0;
      model_reset();

      // Reset and idle
      do_reset(2);
      compare_all("reset");
      chk("sat reset cyc", 64'(s_if.cyc_cnt), 64'd0);
      set_in(1, 0, 0, 5'd0, 32'd0, 0, 0, 0);
      repeat (10) step();
      chk("idle cyc_cnt", 64'(m_if.cyc_cnt), 64'd10);
      compare_all("idle");

      // Directed vector table from a fresh reset
      do_reset(1);
      tv[0]  = mk(1,0,1,3,'h11,0,0,0, 1,1,0,0, 1,3,'h11,0);
      tv[1]  = mk(1,0,1,0,'h22,0,0,0, 2,1,0,0, 1,3,'h11,0);
      tv[2]  = mk(1,0,0,0,0,1,0,0,    3,1,1,0, 1,3,'h11,0);
      tv[3]  = mk(1,0,0,0,0,1,1,0,    4,1,2,1, 1,3,'h11,0);
      tv[4]  = mk(1,0,0,0,0,1,0,0,    5,1,3,1, 1,3,'h11,0);
      tv[5]  = mk(1,0,0,0,0,0,1,0,    6,1,3,2, 1,3,'h11,0);
      tv[6]  = mk(0,0,1,5,'h33,1,1,0, 6,1,3,2, 1,3,'h11,0);
      tv[7]  = mk(0,0,0,0,0,0,0,1,    6,1,3,2, 0,0,0,0);
      tv[8]  = mk(1,0,1,7,'h44,0,0,1, 7,2,3,2, 1,7,'h44,6);
      tv[9]  = mk(1,0,0,0,0,0,0,0,    8,2,3,2, 1,7,'h44,6);
      tv[10] = mk(1,1,1,9,'h55,1,1,1, 0,0,0,0, 0,0,0,0);
      tv[11] = mk(1,0,0,0,0,0,0,0,    1,0,0,0, 0,0,0,0);
      for (int i = 0; i < 12; i++) begin
         set_in(tv[i].en, tv[i].clr, tv[i].wb_en, tv[i].dest, tv[i].data, tv[i].frz, tv[i].fl, tv[i].rdy);
         step();
         chk($sformatf("vec%0d cyc_cnt", i),   64'(m_if.cyc_cnt),   64'(tv[i].e_cyc));
         chk($sformatf("vec%0d ret_cnt", i),   64'(m_if.ret_cnt),   64'(tv[i].e_ret));
         chk($sformatf("vec%0d stall_cnt", i), 64'(m_if.stall_cnt), 64'(tv[i].e_stall));
         chk($sformatf("vec%0d flush_cnt", i), 64'(m_if.flush_cnt), 64'(tv[i].e_flush));
         chk($sformatf("vec%0d tr_valid", i),  64'(m_if.tr_valid),  TRACE ? 64'(tv[i].e_valid) : 64'd0);
         chk($sformatf("vec%0d tr_dest", i),   64'(m_if.tr_dest),   TRACE ? 64'(tv[i].e_dest)  : 64'd0);
         chk($sformatf("vec%0d tr_data", i),   64'(m_if.tr_data),   TRACE ? 64'(tv[i].e_data)  : 64'd0);
         chk($sformatf("vec%0d tr_cycle", i),  64'(m_if.tr_cycle),  TRACE ? 64'(tv[i].e_tcyc)  : 64'd0);
      end

      // Overflow: six commits into a four-deep FIFO, then drain
      set_in(0, 1, 0, 5'd0, 32'd0, 0, 0, 0);
      step();
      compare_all("ovf clr");
      for (int i = 0; i < 6; i++) begin
         set_in(1, 0, 1, 5'(i + 1), 32'h A0 + 32'(i), 0, 0, 0);
         step();
         compare_all("ovf fill");
      end
      set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 0);
      chk("ovf ret_cnt",  64'(m_if.ret_cnt),  64'd6);
      chk("ovf tr_ovf",   64'(m_if.tr_ovf),   TRACE ? 64'd1 : 64'd0);
      chk("ovf drop_cnt", 64'(m_if.drop_cnt), TRACE ? 64'd2 : 64'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d dest", k), 64'(m_if.tr_dest), TRACE ? 64'(k + 1) : 64'd0);
         chk($sformatf("drain%0d data", k), 64'(m_if.tr_data), TRACE ? 64'h A0 + 64'(k) : 64'd0);
         set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 1);
         step();
         compare_all("drain");
      end
      chk("drain empty tr_valid", 64'(m_if.tr_valid), 64'd0);

      // Full FIFO with simultaneous push and pop
      set_in(0, 1, 0, 5'd0, 32'd0, 0, 0, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 1, 5'(11 + i), 32'h B0 + 32'(i), 0, 0, 0);
         step();
      end
      compare_all("full");
      set_in(1, 0, 1, 5'd15, 32'h F5, 0, 0, 1);
      step();
      compare_all("full pushpop");
      chk("pushpop drop_cnt", 64'(m_if.drop_cnt), 64'd0);
      chk("pushpop tr_ovf",   64'(m_if.tr_ovf),   64'd0);
      chk("pushpop head",     64'(m_if.tr_dest),  TRACE ? 64'd12 : 64'd0);
      set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 1);
      repeat (3) step();
      chk("pushpop tail", 64'(m_if.tr_dest), TRACE ? 64'd15 : 64'd0);
      step();
      compare_all("pushpop drained");

      // Saturation on the narrow-counter instance
      set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 0);
      s_if.en = 1'b1; s_if.freeze = 1'b1;
      repeat (14) step();
      chk("sat cyc14", 64'(s_if.cyc_cnt), 64'd14);
      repeat (6) step();
      chk("sat cyc_cnt",   64'(s_if.cyc_cnt),   64'd15);
      chk("sat stall_cnt", 64'(s_if.stall_cnt), 64'd15);
      chk("sat flush_cnt", 64'(s_if.flush_cnt), 64'd0);
      s_if.en = 1'b0; s_if.freeze = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7,
                5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31)), $urandom(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
         step();
         compare_all("rand");
      end

      // Asynchronous reset between edges in the middle of a drain
      set_in(0, 1, 0, 5'd0, 32'd0, 0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 1, 5'(20 + i), 32'h C0 + 32'(i), 1, 1, 0);
         step();
      end
      set_in(0, 0, 0, 5'd0, 32'd0, 0, 0, 1);
      step();
      compare_all("pre-rst");
      #2 rst_n = 1'b0;
      #1;
      chk("arst tr_valid",  64'(m_if.tr_valid),  64'd0);
      chk("arst tr_dest",   64'(m_if.tr_dest),   64'd0);
      chk("arst tr_data",   64'(m_if.tr_data),   64'd0);
      chk("arst tr_cycle",  64'(m_if.tr_cycle),  64'd0);
      chk("arst cyc_cnt",   64'(m_if.cyc_cnt),   64'd0);
      chk("arst ret_cnt",   64'(m_if.ret_cnt),   64'd0);
      chk("arst stall_cnt", 64'(m_if.stall_cnt), 64'd0);
      chk("arst flush_cnt", 64'(m_if.flush_cnt), 64'd0);
      chk("arst tr_ovf",    64'(m_if.tr_ovf),    64'd0);
      chk("arst drop_cnt",  64'(m_if.drop_cnt),  64'd0);
      do_reset(1);
      set_in(1, 0, 1, 5'd9, 32'h D9, 0, 0, 0);
      step();
      compare_all("post-rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
